// File: rtl/dg0045_display_scanner.sv
// Display scanner for the DG0045-class core: captures ND strobes into a digit
// shift buffer and multiplexes hex-decoded digits across one-hot digit enables.
module dg0045_display_scanner #(
   parameter int NDIGITS   = 8,
   parameter int SCAN_DIV  = 1024,
   parameter int BLANK_CYC = 8,
   parameter int MIN_LOW   = 1
) (
   input  logic               clk,
   input  logic               RESET,
   input  logic [3:0]         nL,
   input  logic               ND,
   input  logic               blank_in,
   output logic [6:0]         seg,
   output logic               dp,
   output logic [NDIGITS-1:0] dig_en,
   output logic               frame_tick,
   output logic [7:0]         wr_count
);

   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGITS - 1);
   localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYC);
   localparam logic [1:0]    MIN_LOW_C = 2'(MIN_LOW);

   logic               nd_s1_reg, nd_s2_reg;
   logic [3:0]         nl_s1_reg, nl_s2_reg;
   logic [1:0]         low_cnt_reg;
   logic [3:0]         digit_reg  [NDIGITS];
   logic [3:0]         digit_next [NDIGITS];
   logic [NDIGITS-1:0] dp_mask_reg, dp_mask_next;
   logic [7:0]         wr_count_reg;
   logic [PW-1:0]      pre_reg, pre_next;
   logic [IW-1:0]      idx_reg, idx_next;
   logic [6:0]         seg_reg, seg_next;
   logic               dp_reg, dp_next;
   logic [NDIGITS-1:0] dig_en_reg, dig_en_next;
   logic               frame_tick_reg;
   logic               accept, pre_tc, show;

   function automatic logic [6:0] hex7(input logic [3:0] d);
      case (d)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   // low_cnt still holds the length of the low run in the first high cycle,
   // so that cycle is exactly the 0->1 edge of the synchronized strobe.
   assign accept = nd_s2_reg && (low_cnt_reg >= MIN_LOW_C);

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         nd_s1_reg    <= 1'b1;
         nd_s2_reg    <= 1'b1;
         nl_s1_reg    <= 4'hF;
         nl_s2_reg    <= 4'hF;
         low_cnt_reg  <= 2'd0;
         wr_count_reg <= 8'd0;
         dp_mask_reg  <= '0;
      end else begin
         nd_s1_reg <= ND;
         nd_s2_reg <= nd_s1_reg;
         nl_s1_reg <= nL;
         nl_s2_reg <= nl_s1_reg;
         if (nd_s2_reg)
            low_cnt_reg <= 2'd0;
         else if (low_cnt_reg != 2'd3)
            low_cnt_reg <= low_cnt_reg + 2'd1;
         if (accept)
            wr_count_reg <= wr_count_reg + 8'd1;
         dp_mask_reg <= dp_mask_next;
      end
   end

   assign dp_mask_next = accept ? {dp_mask_reg[NDIGITS-2:0], 1'b0} : dp_mask_reg;

   generate
      for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
         if (gi == 0) begin : g_head
            assign digit_next[gi] = accept ? ~nl_s2_reg : digit_reg[gi];
         end else begin : g_tail
            assign digit_next[gi] = accept ? digit_reg[gi-1] : digit_reg[gi];
         end

         always_ff @(posedge clk or negedge RESET) begin
            if (!RESET)
               digit_reg[gi] <= 4'h0;
            else
               digit_reg[gi] <= digit_next[gi];
         end

         assign dig_en_next[gi] = (idx_next == IW'(gi));
      end
   endgenerate

   assign pre_tc   = (pre_reg == PRE_LAST);
   assign pre_next = pre_tc ? '0 : pre_reg + PW'(1);
   assign idx_next = !pre_tc ? idx_reg : ((idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1));

   // Outputs are computed from next-state values so seg, dp and dig_en change
   // together and a shift coinciding with a slot change is already visible.
   assign show     = (pre_next >= PRE_BLANK) && !blank_in;
   assign seg_next = show ? hex7(digit_next[idx_next]) : 7'h00;
   assign dp_next  = show & dp_mask_next[idx_next];

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         pre_reg        <= '0;
         idx_reg        <= '0;
         seg_reg        <= 7'h00;
         dp_reg         <= 1'b0;
         dig_en_reg     <= '0;
         frame_tick_reg <= 1'b0;
      end else begin
         pre_reg        <= pre_next;
         idx_reg        <= idx_next;
         seg_reg        <= seg_next;
         dp_reg         <= dp_next;
         dig_en_reg     <= dig_en_next;
         frame_tick_reg <= pre_tc && (idx_reg == IDX_LAST);
      end
   end

   assign seg        = seg_reg;
   assign dp         = dp_reg;
   assign dig_en     = dig_en_reg;
   assign frame_tick = frame_tick_reg;
   assign wr_count   = wr_count_reg;

endmodule
